// File: rtl/exec_issue_unit.sv
// Issue arbiter for the INT/MEM/MUL/DIV reservation stations. Grants at most one station per
// cycle and keeps a CDB reservation schedule so no two units ever broadcast in the same cycle.
module exec_issue_unit #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    input  logic       i_int_rdy,
    input  logic       i_mem_rdy,
    input  logic       i_mul_rdy,
    input  logic       i_div_rdy,
    output logic       o_issue_int,
    output logic       o_issue_mem,
    output logic       o_issue_mul,
    output logic       o_issue_div,
    output logic       o_div_busy,
    output logic       o_cdb_valid,
    output logic [1:0] o_cdb_sel
);

    localparam int SW = DIV_LAT + 1;
    localparam int CW = $clog2(DIV_LAT);

    localparam logic [1:0] SEL_INT = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_MUL = 2'd2;
    localparam logic [1:0] SEL_DIV = 2'd3;

    // Entry k: bit 2 = CDB claimed k cycles from now, bits 1:0 = owning unit.
    logic [SW-1:0][2:0] sched_r;
    logic [SW-1:0][2:0] sched_nxt_s;
    logic [CW-1:0]      div_cnt_r;
    logic [CW-1:0]      div_cnt_nxt_s;
    logic               div_busy_r;
    logic               rr_mem_r;
    logic               rr_nxt_s;

    logic int_ok_s, mem_ok_s, mul_ok_s, div_ok_s;
    logic gnt_int_s, gnt_mem_s, gnt_mul_s, gnt_div_s;

    assign int_ok_s = i_int_rdy && !sched_r[1][2];
    assign mem_ok_s = i_mem_rdy && !sched_r[1][2];
    assign mul_ok_s = i_mul_rdy && !sched_r[MUL_LAT][2];
    assign div_ok_s = i_div_rdy && !sched_r[DIV_LAT][2] && !div_busy_r;

    // Fixed priority DIV > MUL, then round-robin between INT and MEM.
    always_comb begin
        gnt_int_s = 1'b0;
        gnt_mem_s = 1'b0;
        gnt_mul_s = 1'b0;
        gnt_div_s = 1'b0;
        if (i_flush) begin
            gnt_div_s = 1'b0;
        end else if (div_ok_s) begin
            gnt_div_s = 1'b1;
        end else if (mul_ok_s) begin
            gnt_mul_s = 1'b1;
        end else if (int_ok_s && mem_ok_s) begin
            gnt_mem_s = rr_mem_r;
            gnt_int_s = !rr_mem_r;
        end else if (int_ok_s) begin
            gnt_int_s = 1'b1;
        end else if (mem_ok_s) begin
            gnt_mem_s = 1'b1;
        end else begin
            gnt_int_s = 1'b0;
        end
    end

    assign o_issue_int = gnt_int_s;
    assign o_issue_mem = gnt_mem_s;
    assign o_issue_mul = gnt_mul_s;
    assign o_issue_div = gnt_div_s;

    // Next schedule: shift toward entry 0 and book the slot of this cycle's grant.
    always_comb begin
        sched_nxt_s = '0;
        for (int k = 0; k < SW - 1; k++) begin
            sched_nxt_s[k] = sched_r[k+1];
        end
        if (i_flush) begin
            sched_nxt_s = '0;
        end else if (gnt_div_s) begin
            sched_nxt_s[DIV_LAT-1] = {1'b1, SEL_DIV};
        end else if (gnt_mul_s) begin
            sched_nxt_s[MUL_LAT-1] = {1'b1, SEL_MUL};
        end else if (gnt_mem_s) begin
            sched_nxt_s[0] = {1'b1, SEL_MEM};
        end else if (gnt_int_s) begin
            sched_nxt_s[0] = {1'b1, SEL_INT};
        end else begin
            sched_nxt_s[SW-1] = 3'b000;
        end
    end

    // Divider occupancy countdown and round-robin pointer update.
    always_comb begin
        div_cnt_nxt_s = '0;
        rr_nxt_s      = rr_mem_r;
        if (i_flush) begin
            div_cnt_nxt_s = '0;
        end else if (gnt_div_s) begin
            div_cnt_nxt_s = CW'(DIV_LAT - 1);
        end else if (div_cnt_r != '0) begin
            div_cnt_nxt_s = div_cnt_r - CW'(1);
        end else begin
            div_cnt_nxt_s = '0;
        end
        if (gnt_int_s || gnt_mem_s) begin
            rr_nxt_s = !rr_mem_r;
        end else begin
            rr_nxt_s = rr_mem_r;
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sched_r    <= '0;
            div_cnt_r  <= '0;
            div_busy_r <= 1'b0;
            rr_mem_r   <= 1'b0;
        end else begin
            sched_r    <= sched_nxt_s;
            div_cnt_r  <= div_cnt_nxt_s;
            div_busy_r <= (div_cnt_nxt_s != '0);
            rr_mem_r   <= rr_nxt_s;
        end
    end

    assign o_div_busy  = div_busy_r;
    assign o_cdb_valid = sched_r[0][2];
    assign o_cdb_sel   = sched_r[0][1:0];

endmodule

// File: tb/tb_exec_issue_unit.sv
// Bench for exec_issue_unit: directed vector table, hand sequences and random stimulus,
// all checked against a cycle-indexed CDB booking model.
module tb_exec_issue_unit;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;
    localparam int NCYC    = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       int_rdy = 1'b0, mem_rdy = 1'b0, mul_rdy = 1'b0, div_rdy = 1'b0;
    logic       issue_int, issue_mem, issue_mul, issue_div;
    logic       div_busy, cdb_valid;
    logic [1:0] cdb_sel;

    exec_issue_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_int_rdy(int_rdy), .i_mem_rdy(mem_rdy), .i_mul_rdy(mul_rdy), .i_div_rdy(div_rdy),
        .o_issue_int(issue_int), .o_issue_mem(issue_mem), .o_issue_mul(issue_mul),
        .o_issue_div(issue_div), .o_div_busy(div_busy), .o_cdb_valid(cdb_valid),
        .o_cdb_sel(cdb_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: claim[c] = unit id owning the CDB in absolute cycle c, -1 if free.
    int claim [NCYC];
    int cyc;
    int div_last;
    bit rr_mem;

    typedef struct {
        logic [3:0] rdy;   // {div, mul, mem, int}
        logic       fl;
        logic [3:0] g;
        logic       v;
        logic [1:0] s;
        logic       b;
    } vec_t;
    vec_t tab [26];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCYC; i++) claim[i] = -1;
        div_last = -1000;
        rr_mem   = 1'b0;
    endfunction

    function automatic int lat_of(input int id);
        if (id == 3) return DIV_LAT;
        if (id == 2) return MUL_LAT;
        return 1;
    endfunction

    // One cycle: drive, compare at negedge against the model (and optionally a table row), advance.
    task automatic run_cycle(input logic [3:0] rdy, input logic fl, input bit use_tab,
                             input vec_t row, output logic [3:0] eg);
        logic [3:0] act;
        bit         busy_m, ok [4];
        int         gid;
        {div_rdy, mul_rdy, mem_rdy, int_rdy} = rdy;
        flush = fl;
        @(negedge clk);
        busy_m = (cyc > div_last) && (cyc < div_last + DIV_LAT);
        for (int u = 0; u < 4; u++) ok[u] = rdy[u] && (claim[cyc + lat_of(u)] < 0);
        ok[3] = ok[3] && !busy_m;
        gid = -1;
        if (!fl) begin
            if (ok[3]) gid = 3;
            else if (ok[2]) gid = 2;
            else if (ok[0] && ok[1]) gid = rr_mem ? 1 : 0;
            else if (ok[0]) gid = 0;
            else if (ok[1]) gid = 1;
        end
        eg = (gid < 0) ? 4'b0000 : 4'(1 << gid);
        act = {issue_div, issue_mul, issue_mem, issue_int};
        check("grant", int'(act), int'(eg));
        check("cdb_valid", int'(cdb_valid), (claim[cyc] >= 0) ? 1 : 0);
        check("cdb_sel", int'(cdb_sel), (claim[cyc] >= 0) ? claim[cyc] : 0);
        check("div_busy", int'(div_busy), int'(busy_m));
        if (use_tab) begin
            check("tab_grant", int'(act), int'(row.g));
            check("tab_cdb_valid", int'(cdb_valid), int'(row.v));
            check("tab_cdb_sel", int'(cdb_sel), int'(row.s));
            check("tab_div_busy", int'(div_busy), int'(row.b));
        end
        if (gid >= 0) begin
            claim[cyc + lat_of(gid)] = gid;
            if (gid <= 1) rr_mem = !rr_mem;
            if (gid == 3) div_last = cyc;
        end
        if (fl) begin
            for (int j = cyc + 1; j <= cyc + DIV_LAT + 1; j++) claim[j] = -1;
            div_last = -1000;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grants"}, int'({issue_div, issue_mul, issue_mem, issue_int}), 0);
        check({tag, "_cdb_valid"}, int'(cdb_valid), 0);
        check({tag, "_cdb_sel"}, int'(cdb_sel), 0);
        check({tag, "_div_busy"}, int'(div_busy), 0);
    endtask

    function automatic vec_t mk(input logic [3:0] rdy, input logic fl, input logic [3:0] g,
                                input logic v, input logic [1:0] s, input logic b);
        vec_t r;
        r.rdy = rdy; r.fl = fl; r.g = g; r.v = v; r.s = s; r.b = b;
        return r;
    endfunction

    initial begin
        logic [3:0] g, rdy;
        vec_t       none;
        none = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        cyc = 0;
        model_reset();

        // INT single shot, MUL blocking INT's slot, back-to-back DIV, then flush during DIV.
        tab[0]  = mk(4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0);
        tab[1]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        tab[2]  = mk(4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0);
        tab[3]  = none;
        tab[4]  = none;
        tab[5]  = mk(4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        tab[6]  = mk(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd2, 1'b0);
        tab[7]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
        tab[8]  = none;
        tab[9]  = mk(4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0);
        for (int i = 10; i <= 16; i++) tab[i] = mk(4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
        tab[17] = mk(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        tab[18] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
        tab[19] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
        tab[20] = mk(4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);
        tab[21] = mk(4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b0);
        for (int i = 22; i <= 25; i++) tab[i] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) run_cycle(tab[i].rdy, tab[i].fl, 1'b1, tab[i], g);
        repeat (6) run_cycle(4'b0000, 1'b0, 1'b0, none, g);

        // INT and MEM held together: alternate.
        for (int i = 0; i < 8; i++) run_cycle(4'b0011, 1'b0, 1'b0, none, g);
        repeat (3) run_cycle(4'b0000, 1'b0, 1'b0, none, g);

        // All four ready: DIV, then MUL, then INT/MEM around the booked slots.
        rdy = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            run_cycle(rdy, 1'b0, 1'b0, none, g);
            rdy = rdy & ~(g & 4'b1100);
        end

        // Asynchronous reset in the middle of activity.
        run_cycle(4'b1100, 1'b0, 1'b0, none, g);
        {div_rdy, mul_rdy, mem_rdy, int_rdy} = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;

        for (int i = 0; i < 3000; i++) begin
            for (int u = 0; u < 4; u++) rdy[u] = ($urandom_range(0, 99) < 40);
            run_cycle(rdy, ($urandom_range(0, 63) == 0), 1'b0, none, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
